// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects and load-use stall detection for the ID stage.
// Optional FWD_STATS_EN adds stall_cnt/fwd_cnt event counters.
module fwd_hazard_ctrl #(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RA_W-1:0] id_rn,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic            flush,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            stall,
    output logic [RA_W-1:0] exe_rn,
    output logic            exe_wreg,
    output logic            exe_m2reg,
    output logic [RA_W-1:0] mem_rn,
    output logic            mem_wreg,
    output logic            mem_m2reg
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     fwd_cnt
`endif
);

    // EXE match beats MEM match; a load still in EXE has no data yet, so it falls through.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            use_src,
        input logic [RA_W-1:0] e_rn,
        input logic            e_wreg,
        input logic            e_m2reg,
        input logic [RA_W-1:0] m_rn,
        input logic            m_wreg,
        input logic            m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src == '0 || !use_src)
            sel = 2'b00;
        else if (e_wreg && e_rn == src && !e_m2reg)
            sel = 2'b01;
        else if (m_wreg && m_rn == src && !m_m2reg)
            sel = 2'b10;
        else if (m_wreg && m_rn == src && m_m2reg)
            sel = 2'b11;
        return sel;
    endfunction

    logic bubble;

    always_comb begin
        fwda = fwd_sel(id_rs, id_use_rs, exe_rn, exe_wreg, exe_m2reg,
                       mem_rn, mem_wreg, mem_m2reg);
        fwdb = fwd_sel(id_rt, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
                       mem_rn, mem_wreg, mem_m2reg);
        stall = exe_wreg && exe_m2reg && (exe_rn != '0) &&
                ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));
        bubble = stall || flush;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            exe_rn    <= '0;
            exe_wreg  <= 1'b0;
            exe_m2reg <= 1'b0;
            mem_rn    <= '0;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
        end else begin
            mem_rn    <= exe_rn;
            mem_wreg  <= exe_wreg;
            mem_m2reg <= exe_m2reg;
            exe_rn    <= bubble ? '0 : id_rn;
            exe_wreg  <= bubble ? 1'b0 : id_wreg;
            exe_m2reg <= bubble ? 1'b0 : id_m2reg;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (!clrn) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            // one count per cycle even when both operands forward
            if (fwda != 2'b00 || fwdb != 2'b00)
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule
